progmem_loader: RTL and testbench
=================================

Name: progmem_loader

Overview:
Parametrised instruction memory with a built-in byte-stream upgrade loader, the next generation of our program ROM.
- In RUN mode it serves instruction fetches with one-cycle registered latency.
- In LOAD mode it takes bytes from the UART front end, packs them little-endian into DATA_W-bit words and writes them to consecutive addresses from 0.
- It reports progress, busy state and overflow to the CPU top level.

Parameters:
ADDR_W, 14, word-address width; depth = 2**ADDR_W words
DATA_W, 32, instruction width; must be a multiple of 8; BYTES = DATA_W/8

Ports:
clk_i  in  1  single clock; all logic on rising edge
rst_n_i  in  1  asynchronous, active-low reset
adr_i  in  ADDR_W  fetch word address
instruction_o  out  DATA_W  registered fetch data
instr_valid_o  out  1  instruction_o holds mem[adr_i] sampled on the previous edge
upg_start_i  in  1  single-cycle pulse; enter LOAD (honoured only in RUN)
upg_valid_i  in  1  upg_byte_i valid
upg_byte_i  in  8  upgrade data byte
upg_ready_o  out  1  loader accepts a byte this cycle
upg_done_i  in  1  end of stream (level or pulse; sampled in LOAD only)
busy_o  out  1  state != RUN
words_o  out  ADDR_W+1  words successfully written since last upg_start_i
overflow_o  out  1  sticky; set when a word is committed past the last address

Behaviour:
Reset (rst_n_i low, asynchronous):
- state=RUN.
- instruction_o=0, instr_valid_o=0, upg_ready_o=0, busy_o=0, words_o=0, overflow_o=0.
- Internal: byte_cnt=0, wr_adr=0, asm=0, done_pend=0.
- Memory contents are not reset.
- Reset mid-load abandons the load; words already written stay in memory.

RUN:
- Every edge: instruction_o<=mem[adr_i], instr_valid_o<=1. Latency is one cycle.
- upg_ready_o=0; upg_valid_i and upg_done_i are ignored.
- upg_start_i=1 -> LOAD. On the same edge: wr_adr=0, byte_cnt=0, asm=0, words_o=0, overflow_o=0, done_pend=0, instr_valid_o<=0.

LOAD:
- upg_ready_o=1. instruction_o holds its last value; instr_valid_o=0.
- On upg_valid_i: asm[8*byte_cnt +: 8]<=upg_byte_i (first byte goes to bits 7:0), byte_cnt++.
- If that byte is lane BYTES-1 -> COMMIT.
- upg_done_i in the same cycle: done_pend<=1.
  - Word completes this cycle: -> COMMIT, then RUN.
  - Otherwise, byte_cnt after update > 0: -> FLUSH.
  - Otherwise: -> RUN.
- upg_done_i with no byte: byte_cnt>0 -> FLUSH; else -> RUN.
- upg_start_i is ignored outside RUN.

COMMIT (one cycle, upg_ready_o=0):
- wr_adr < 2**ADDR_W: mem[wr_adr]<=asm, words_o++.
- Otherwise: no write, overflow_o<=1.
- Then: wr_adr++ (saturate at 2**ADDR_W), byte_cnt=0, asm=0.
- Next state: done_pend ? RUN : LOAD.

FLUSH (one cycle, upg_ready_o=0):
- Same write and overflow rule as COMMIT, using the zero-padded partial asm.
- -> RUN; done_pend cleared.

Return to RUN:
- The first fetch after return is issued on the RUN entry edge; instr_valid_o=1 on the following cycle.

Width rules:
- wr_adr is ADDR_W+1 bits; the top bit set means overflow.
- words_o never exceeds 2**ADDR_W.

Write port:
- Single write port, used only in COMMIT/FLUSH. Read and write never coincide because fetch is idle outside RUN.

Test Plan:
- Reset then RUN fetch: hold rst_n_i low, release; adr_i=5 -> instr_valid_o=1 one cycle later, instruction_o=mem[5]; all status outputs 0.
- Full-word load: upg_start_i; send bytes 0x13,0x05,0x10,0x00 then 0xEF,0xBE,0xAD,0xDE; upg_done_i -> mem[0]=0x00100513, mem[1]=0xDEADBEEF, words_o=2, back in RUN, fetch adr_i=1 returns 0xDEADBEEF.
- Partial flush: load 6 bytes 0x01..0x06 then upg_done_i -> mem[1]=0x00000605, words_o=2, FLUSH visited once.
- Simultaneous last byte and done: 4th byte 0xAA with upg_done_i high -> single COMMIT of 0xAA......, no FLUSH, words_o=1, RUN.
- Backpressure and gaps: random upg_valid_i gaps; verify upg_ready_o=0 during COMMIT; no byte lost or duplicated over 64 words against a scoreboard.
- Overflow and reset: ADDR_W=2, load 5 words -> mem[0..3] written, words_o=4, overflow_o=1. Separately, assert rst_n_i mid-word -> immediate RUN, outputs 0, earlier words intact.

Source files
------------

// File: rtl/progmem_loader.sv
// rtl/progmem_loader.sv - instruction memory with byte-stream upgrade loader
module progmem_loader #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] adr_i,
    output logic [DATA_W-1:0] instruction_o,
    output logic              instr_valid_o,
    input  logic              upg_start_i,
    input  logic              upg_valid_i,
    input  logic [7:0]        upg_byte_i,
    output logic              upg_ready_o,
    input  logic              upg_done_i,
    output logic              busy_o,
    output logic [ADDR_W:0]   words_o,
    output logic              overflow_o
);
    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = $clog2(BYTES + 1);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] ONE_W = 1;
    localparam logic [CNT_W-1:0] ONE_C = 1;

    typedef enum logic [1:0] {S_RUN, S_LOAD, S_COMMIT, S_FLUSH} state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [CNT_W-1:0]    r_byte_cnt;
    logic [ADDR_W:0]     r_wr_adr;
    logic [DATA_W-1:0]   r_asm;
    logic                r_done_pend;
    logic [DATA_W-1:0]   r_instr;
    logic                r_instr_valid;
    logic                r_ready;
    logic                r_busy;
    logic [ADDR_W:0]     r_words;
    logic                r_overflow;

    logic [DATA_W-1:0]   w_asm_upd;
    logic                w_last_lane;
    logic                w_we;

    assign w_last_lane = (r_byte_cnt == CNT_W'(BYTES - 1));
    // Writes happen only while committing; top bit of wr_adr marks the past-the-end slot
    assign w_we = ((r_state == S_COMMIT) || (r_state == S_FLUSH)) && !r_wr_adr[ADDR_W];

    // Assembly word with the incoming byte dropped into its little-endian lane
    always_comb begin
        w_asm_upd = r_asm;
        w_asm_upd[8*r_byte_cnt +: 8] = upg_byte_i;
    end

    // Single write port; fetch is idle outside RUN so read and write never collide
    always_ff @(posedge clk_i) begin
        if (w_we) begin
            r_mem[r_wr_adr[ADDR_W-1:0]] <= r_asm;
        end
    end

    // Mode FSM with registered fetch path and status outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state       <= S_RUN;
            r_byte_cnt    <= '0;
            r_wr_adr      <= '0;
            r_asm         <= '0;
            r_done_pend   <= 1'b0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_ready       <= 1'b0;
            r_busy        <= 1'b0;
            r_words       <= '0;
            r_overflow    <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (upg_start_i) begin
                        r_state       <= S_LOAD;
                        r_wr_adr      <= '0;
                        r_byte_cnt    <= '0;
                        r_asm         <= '0;
                        r_words       <= '0;
                        r_overflow    <= 1'b0;
                        r_done_pend   <= 1'b0;
                        r_instr_valid <= 1'b0;
                        r_ready       <= 1'b1;
                        r_busy        <= 1'b1;
                    end else begin
                        r_instr       <= r_mem[adr_i];
                        r_instr_valid <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (upg_valid_i) begin
                        r_asm      <= w_asm_upd;
                        r_byte_cnt <= r_byte_cnt + ONE_C;
                    end
                    if (upg_valid_i && w_last_lane) begin
                        // Full word: commit it, and finish afterwards if the stream also ended
                        r_state     <= S_COMMIT;
                        r_ready     <= 1'b0;
                        r_done_pend <= upg_done_i;
                    end else if (upg_done_i) begin
                        r_ready <= 1'b0;
                        if (upg_valid_i || (r_byte_cnt != '0)) begin
                            r_state     <= S_FLUSH;
                            r_done_pend <= 1'b1;
                        end else begin
                            r_state     <= S_RUN;
                            r_busy      <= 1'b0;
                            r_done_pend <= 1'b0;
                        end
                    end
                end
                S_COMMIT, S_FLUSH: begin
                    if (!r_wr_adr[ADDR_W]) begin
                        r_words  <= r_words + ONE_W;
                        r_wr_adr <= r_wr_adr + ONE_W;
                    end else begin
                        r_overflow <= 1'b1;
                    end
                    r_byte_cnt <= '0;
                    r_asm      <= '0;
                    if ((r_state == S_FLUSH) || r_done_pend) begin
                        r_state     <= S_RUN;
                        r_busy      <= 1'b0;
                        r_ready     <= 1'b0;
                        r_done_pend <= 1'b0;
                    end else begin
                        r_state <= S_LOAD;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign instruction_o = r_instr;
    assign instr_valid_o = r_instr_valid;
    assign upg_ready_o   = r_ready;
    assign busy_o        = r_busy;
    assign words_o       = r_words;
    assign overflow_o    = r_overflow;
endmodule

// File: tb/tb_progmem_loader.sv
// tb/tb_progmem_loader.sv - randomized self-checking bench for progmem_loader
module tb_progmem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  adr = '0;
    logic [1:0]  adr2;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  byt = '0;
    logic        done = 1'b0;

    logic [31:0] instr1, instr2;
    logic        iv1, iv2, rdy1, rdy2, busy1, busy2, ov1, ov2;
    logic [7:0]  words1;
    logic [2:0]  words2;

    int checks = 0;
    int failures = 0;

    logic [7:0]  q[$];
    logic [31:0] m1[128];
    logic [31:0] m2[4];

    assign adr2 = adr[1:0];

    always #5 clk = ~clk;

    progmem_loader #(.ADDR_W(7), .DATA_W(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .adr_i(adr),
        .instruction_o(instr1), .instr_valid_o(iv1),
        .upg_start_i(start), .upg_valid_i(valid), .upg_byte_i(byt),
        .upg_ready_o(rdy1), .upg_done_i(done),
        .busy_o(busy1), .words_o(words1), .overflow_o(ov1)
    );

    progmem_loader #(.ADDR_W(2), .DATA_W(32)) dut_small (
        .clk_i(clk), .rst_n_i(rst_n), .adr_i(adr2),
        .instruction_o(instr2), .instr_valid_o(iv2),
        .upg_start_i(start), .upg_valid_i(valid), .upg_byte_i(byt),
        .upg_ready_o(rdy2), .upg_done_i(done),
        .busy_o(busy2), .words_o(words2), .overflow_o(ov2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word w of the current stream: bytes packed little-endian, missing bytes zero
    function automatic logic [31:0] pack_word(input int w);
        logic [31:0] v = '0;
        for (int l = 0; l < 4; l++) begin
            if (w * 4 + l < q.size()) v[8*l +: 8] = q[w * 4 + l];
        end
        return v;
    endfunction

    // mode 0: done after the last byte (held as a level), 1: done with the last byte,
    // 2: no done, stop once all bytes are accepted (caller then resets)
    task automatic run_stream(input int mode, input int gap_pct);
        int n = q.size();
        int acc = 0;
        int cyc = 0;
        int nr1 = 0;
        int nr2 = 0;
        int nw;
        bit r;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ready_after_start", {63'd0, rdy1}, 64'd1);
        chk("busy_after_start", {63'd0, busy1}, 64'd1);
        while (cyc < 5000) begin
            if (busy1 && !rdy1) nr1++;
            if (busy2 && !rdy2) nr2++;
            if (!busy1) break;
            if (mode == 2 && acc == n) break;
            r = rdy1;
            valid = 1'b0;
            done = 1'b0;
            byt = 8'($urandom);
            if (acc < n) begin
                if (int'($urandom_range(99)) >= gap_pct) begin
                    valid = 1'b1;
                    byt = q[acc];
                    if (mode == 1 && acc == n - 1) done = 1'b1;
                end
            end else if (mode == 0) begin
                done = 1'b1;
            end
            @(negedge clk);
            if (valid && r) begin
                acc++;
                if (acc % 4 == 0) chk("ready_low_in_commit", {63'd0, rdy1}, 64'd0);
            end
            cyc++;
        end
        valid = 1'b0;
        done = 1'b0;
        chk("stream_within_budget", {63'd0, cyc < 5000}, 64'd1);
        if (mode == 2) nw = n / 4;
        else nw = (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            if (w < 128) m1[w] = pack_word(w);
            if (w < 4) m2[w] = pack_word(w);
        end
        if (mode != 2) begin
            chk("commit_cycles_big", 64'(nr1), 64'(nw));
            chk("commit_cycles_small", 64'(nr2), 64'(nw));
            chk("words_big", 64'(words1), 64'(nw > 128 ? 128 : nw));
            chk("words_small", 64'(words2), 64'(nw > 4 ? 4 : nw));
            chk("overflow_big", {63'd0, ov1}, {63'd0, nw > 128});
            chk("overflow_small", {63'd0, ov2}, {63'd0, nw > 4});
            chk("busy_after_stream", {63'd0, busy1}, 64'd0);
        end
    endtask

    task automatic check_mem(input int nw);
        for (int a = 0; a < nw; a++) begin
            adr = 7'(a);
            @(negedge clk);
            chk("fetch_valid", {63'd0, iv1}, 64'd1);
            chk("fetch_big", 64'(instr1), 64'(m1[a]));
            if (a < 4) chk("fetch_small", 64'(instr2), 64'(m2[a]));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_instr", 64'(instr1), 64'd0);
        chk("rst_valid", {63'd0, iv1}, 64'd0);
        chk("rst_ready", {63'd0, rdy1}, 64'd0);
        chk("rst_busy", {63'd0, busy1}, 64'd0);
        chk("rst_words", 64'(words1), 64'd0);
        chk("rst_overflow", {63'd0, ov1}, 64'd0);
        rst_n = 1'b1;
        adr = 7'd5;
        @(negedge clk);
        chk("run_valid_after_reset", {63'd0, iv1}, 64'd1);

        // Full-word load
        q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_stream(0, 0);
        adr = 7'd1;
        @(negedge clk);
        chk("deadbeef", 64'(instr1), 64'hDEAD_BEEF);
        adr = 7'd0;
        @(negedge clk);
        chk("addi_word", 64'(instr1), 64'h0010_0513);

        // Partial flush
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_stream(0, 0);
        adr = 7'd1;
        @(negedge clk);
        chk("flush_word", 64'(instr1), 64'h0000_0605);

        // Last byte and done together
        q.delete();
        for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
        q.push_back(8'hAA);
        run_stream(1, 0);
        adr = 7'd0;
        @(negedge clk);
        chk("aa_top_byte", 64'(instr1[31:24]), 64'hAA);
        check_mem(1);

        // 64 random words with gaps
        q.delete();
        for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
        run_stream(0, 40);
        check_mem(64);

        // Random partial length, done with the last byte
        q.delete();
        for (int i = 0; i < 4 * 3 + 1 + int'($urandom_range(2)); i++) q.push_back(8'($urandom));
        run_stream(1, 25);
        check_mem(4);

        // Five words: the small instance overflows
        q.delete();
        for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
        run_stream(1, 20);
        check_mem(5);

        // Reset in the middle of a word
        q.delete();
        for (int i = 0; i < 10; i++) q.push_back(8'($urandom));
        run_stream(2, 30);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy1}, 64'd0);
        chk("midrst_ready", {63'd0, rdy1}, 64'd0);
        chk("midrst_words", 64'(words1), 64'd0);
        chk("midrst_overflow_small", {63'd0, ov2}, 64'd0);
        chk("midrst_instr", 64'(instr1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_mem(64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
